// File: rtl/multicycle_control.sv
// Main control FSM for a multicycle MIPS-style datapath.
// Datapath controls are decoded from the state register. FETCH write enables also follow mem_ready.
module multicycle_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Op,
    input  logic       mem_ready,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUOP,
    output logic [1:0] PCSrc,
    output logic [3:0] state,
    output logic       illegal_op
);

    localparam int unsigned STATE_W = 4;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_FUNC = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    typedef enum logic [STATE_W-1:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        ALUWB   = 4'd7,
        BEQ     = 4'd8,
        IMMEX   = 4'd9,
        IMMWB   = 4'd10,
        JUMP    = 4'd11
    } state_t;

    state_t cur;

    // State register and illegal-opcode pulse; unused codes recover to FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur        <= FETCH;
            illegal_op <= 1'b0;
        end else begin
            illegal_op <= 1'b0;
            case (cur)
                FETCH:   if (mem_ready) cur <= DECODE;
                DECODE: begin
                    case (Op)
                        OP_LW, OP_SW:                      cur <= MEMADR;
                        OP_RTYPE:                          cur <= RTYPEEX;
                        OP_BEQ:                            cur <= BEQ;
                        OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: cur <= IMMEX;
                        OP_J:                              cur <= JUMP;
                        default: begin
                            cur        <= FETCH;
                            illegal_op <= 1'b1;
                        end
                    endcase
                end
                MEMADR:  cur <= (Op == OP_LW) ? MEMRD : MEMWR;
                MEMRD:   if (mem_ready) cur <= MEMWB;
                MEMWB:   cur <= FETCH;
                MEMWR:   if (mem_ready) cur <= FETCH;
                RTYPEEX: cur <= ALUWB;
                ALUWB:   cur <= FETCH;
                BEQ:     cur <= FETCH;
                IMMEX:   cur <= IMMWB;
                IMMWB:   cur <= FETCH;
                JUMP:    cur <= FETCH;
                default: cur <= FETCH;
            endcase
        end
    end

    assign state = cur;

    logic mem_read_d, mem_write_d, ir_write_d, reg_write_d, pc_write_d, pc_write_cond_d;

    // Moore output decode.
    always_comb begin
        IorD            = 1'b0;
        mem_read_d      = 1'b0;
        mem_write_d     = 1'b0;
        ir_write_d      = 1'b0;
        RegDst          = 1'b0;
        MemtoReg        = 1'b0;
        reg_write_d     = 1'b0;
        ALUSrcA         = 1'b0;
        pc_write_d      = 1'b0;
        pc_write_cond_d = 1'b0;
        ALUSrcB         = 2'b00;
        ALUOP           = ALU_ADD;
        PCSrc           = 2'b00;
        case (cur)
            FETCH: begin
                mem_read_d = 1'b1;
                ALUSrcB    = 2'b01;
                ir_write_d = mem_ready;
                pc_write_d = mem_ready;
            end
            DECODE:  ALUSrcB = 2'b11;
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            MEMRD: begin
                IorD       = 1'b1;
                mem_read_d = 1'b1;
            end
            MEMWB: begin
                MemtoReg    = 1'b1;
                reg_write_d = 1'b1;
            end
            MEMWR: begin
                IorD        = 1'b1;
                mem_write_d = 1'b1;
            end
            RTYPEEX: begin
                ALUSrcA = 1'b1;
                ALUOP   = ALU_FUNC;
            end
            ALUWB: begin
                RegDst      = 1'b1;
                reg_write_d = 1'b1;
            end
            BEQ: begin
                ALUSrcA         = 1'b1;
                ALUOP           = ALU_SUB;
                PCSrc           = 2'b01;
                pc_write_cond_d = 1'b1;
            end
            IMMEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                case (Op)
                    OP_ANDI: ALUOP = ALU_AND;
                    OP_ORI:  ALUOP = ALU_OR;
                    OP_SLTI: ALUOP = ALU_SLT;
                    default: ALUOP = ALU_ADD;
                endcase
            end
            IMMWB:   reg_write_d = 1'b1;
            JUMP: begin
                PCSrc      = 2'b10;
                pc_write_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset suppresses all memory and architectural write strobes.
    assign MemRead     = rst_n & mem_read_d;
    assign MemWrite    = rst_n & mem_write_d;
    assign IRWrite     = rst_n & ir_write_d;
    assign RegWrite    = rst_n & reg_write_d;
    assign PCWrite     = rst_n & pc_write_d;
    assign PCWriteCond = rst_n & pc_write_cond_d;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] Op;
    logic       mem_ready;
    logic       IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite;
    logic       ALUSrcA, PCWrite, PCWriteCond, illegal_op;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ALUOP;
    logic [3:0] state;

    int vectors = 0;
    int miscompares = 0;

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .Op(Op), .mem_ready(mem_ready),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .ALUSrcB(ALUSrcB), .ALUOP(ALUOP),
        .PCSrc(PCSrc), .state(state), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; mem_ready = 1'b1; Op = 6'b000000;
        #1;
        chk("rst_state", 8'(state), 8'd0);
        chk("rst_memread", 8'(MemRead), 8'd0);
        chk("rst_irwrite", 8'(IRWrite), 8'd0);
        chk("rst_pcwrite", 8'(PCWrite), 8'd0);
        chk("rst_illegal", 8'(illegal_op), 8'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("fetch_memread", 8'(MemRead), 8'd1);
        chk("fetch_alusrcb", 8'(ALUSrcB), 8'd1);
        chk("fetch_irwrite", 8'(IRWrite), 8'd1);

        // lw
        Op = 6'b100011;
        tick(); chk("lw_s1", 8'(state), 8'd1);
        chk("lw_dec_srcb", 8'(ALUSrcB), 8'd3);
        chk("lw_dec_regwr", 8'(RegWrite), 8'd0);
        tick(); chk("lw_s2", 8'(state), 8'd2);
        chk("lw_adr_srcb", 8'(ALUSrcB), 8'd2);
        tick(); chk("lw_s3", 8'(state), 8'd3);
        chk("lw_rd_iord", 8'(IorD), 8'd1);
        chk("lw_rd_regwr", 8'(RegWrite), 8'd0);
        tick(); chk("lw_s4", 8'(state), 8'd4);
        chk("lw_wb_regwr", 8'(RegWrite), 8'd1);
        chk("lw_wb_memtoreg", 8'(MemtoReg), 8'd1);
        tick(); chk("lw_s0", 8'(state), 8'd0);
        chk("lw_end_regwr", 8'(RegWrite), 8'd0);
        chk("lw_end_memtoreg", 8'(MemtoReg), 8'd0);

        // R-type
        Op = 6'b000000;
        tick(); chk("r_s1", 8'(state), 8'd1);
        tick(); chk("r_s6", 8'(state), 8'd6);
        chk("r_aluop", 8'(ALUOP), 8'd4);
        chk("r_srcb", 8'(ALUSrcB), 8'd0);
        tick(); chk("r_s7", 8'(state), 8'd7);
        chk("r_regdst", 8'(RegDst), 8'd1);
        chk("r_regwr", 8'(RegWrite), 8'd1);
        chk("r_wb_aluop", 8'(ALUOP), 8'd0);
        tick(); chk("r_s0", 8'(state), 8'd0);
        chk("r_end_regwr", 8'(RegWrite), 8'd0);

        // ori
        Op = 6'b001101;
        tick(); chk("ori_s1", 8'(state), 8'd1);
        tick(); chk("ori_s9", 8'(state), 8'd9);
        chk("ori_aluop", 8'(ALUOP), 8'd3);
        chk("ori_srcb", 8'(ALUSrcB), 8'd2);
        tick(); chk("ori_s10", 8'(state), 8'd10);
        chk("ori_regwr", 8'(RegWrite), 8'd1);
        chk("ori_regdst", 8'(RegDst), 8'd0);
        tick(); chk("ori_s0", 8'(state), 8'd0);

        // slti
        Op = 6'b001010;
        tick(); tick(); chk("slti_s9", 8'(state), 8'd9);
        chk("slti_aluop", 8'(ALUOP), 8'd7);
        tick(); tick(); chk("slti_s0", 8'(state), 8'd0);

        // beq
        Op = 6'b000100;
        tick(); chk("beq_s1", 8'(state), 8'd1);
        tick(); chk("beq_s8", 8'(state), 8'd8);
        chk("beq_pcwc", 8'(PCWriteCond), 8'd1);
        chk("beq_aluop", 8'(ALUOP), 8'd1);
        chk("beq_pcsrc", 8'(PCSrc), 8'd1);
        chk("beq_pcwrite", 8'(PCWrite), 8'd0);
        tick(); chk("beq_s0", 8'(state), 8'd0);

        // j
        Op = 6'b000010;
        tick(); chk("j_s1", 8'(state), 8'd1);
        tick(); chk("j_s11", 8'(state), 8'd11);
        chk("j_pcwrite", 8'(PCWrite), 8'd1);
        chk("j_pcsrc", 8'(PCSrc), 8'd2);
        tick(); chk("j_s0", 8'(state), 8'd0);

        // FETCH wait states, then sw with MEMWR wait states
        mem_ready = 1'b0; Op = 6'b101011;
        #1;
        chk("fw_irwrite0", 8'(IRWrite), 8'd0);
        chk("fw_pcwrite0", 8'(PCWrite), 8'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("fw_hold_state", 8'(state), 8'd0);
            chk("fw_hold_irwrite", 8'(IRWrite), 8'd0);
        end
        mem_ready = 1'b1;
        #1;
        chk("fw_ready_irwrite", 8'(IRWrite), 8'd1);
        chk("fw_ready_pcwrite", 8'(PCWrite), 8'd1);
        tick(); chk("sw_s1", 8'(state), 8'd1);
        chk("sw_dec_irwrite", 8'(IRWrite), 8'd0);
        chk("sw_dec_pcwrite", 8'(PCWrite), 8'd0);
        tick(); chk("sw_s2", 8'(state), 8'd2);
        tick(); chk("sw_s5", 8'(state), 8'd5);
        chk("sw_memwrite", 8'(MemWrite), 8'd1);
        chk("sw_iord", 8'(IorD), 8'd1);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("sw_hold_state", 8'(state), 8'd5);
            chk("sw_hold_memwrite", 8'(MemWrite), 8'd1);
        end
        mem_ready = 1'b1;
        tick(); chk("sw_s0", 8'(state), 8'd0);
        chk("sw_end_memwrite", 8'(MemWrite), 8'd0);

        // Illegal opcode
        Op = 6'b111111;
        tick(); chk("ill_s1", 8'(state), 8'd1);
        chk("ill_pre", 8'(illegal_op), 8'd0);
        tick(); chk("ill_s0", 8'(state), 8'd0);
        chk("ill_pulse", 8'(illegal_op), 8'd1);
        Op = 6'b100011;
        tick(); chk("ill_post_s1", 8'(state), 8'd1);
        chk("ill_post", 8'(illegal_op), 8'd0);

        // Reset in the middle of lw
        tick(); chk("rl_s2", 8'(state), 8'd2);
        tick(); chk("rl_s3", 8'(state), 8'd3);
        rst_n = 1'b0;
        #1;
        chk("rl_async_state", 8'(state), 8'd0);
        chk("rl_memread", 8'(MemRead), 8'd0);
        chk("rl_regwrite", 8'(RegWrite), 8'd0);
        chk("rl_irwrite", 8'(IRWrite), 8'd0);
        tick();
        chk("rl_hold_state", 8'(state), 8'd0);
        chk("rl_hold_memread", 8'(MemRead), 8'd0);
        chk("rl_hold_pcwrite", 8'(PCWrite), 8'd0);
        chk("rl_hold_memwrite", 8'(MemWrite), 8'd0);
        rst_n = 1'b1;
        #1;
        chk("rl_rel_memread", 8'(MemRead), 8'd1);
        tick(); chk("rl_rel_s1", 8'(state), 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; all state changes SHALL occur on the rising edge of clk.
REQ-002 Ports (name direction width meaning):
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- Op  in  6  opcode from IR[31:26]; stable from DECODE to end of instruction
- mem_ready  in  1  memory completes the current access this cycle
- IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCWrite, PCWriteCond  out  1 each  datapath controls
- ALUSrcB  out  2  ALU B select: 00 reg, 01 const 4, 10 signext imm, 11 imm<<2
- ALUOP  out  3  to ALU control: 000 add, 001 sub, 010 and, 011 or, 111 slt, 100 decode funct
- PCSrc  out  2  00 ALU result, 01 ALUOut, 10 jump target
- state  out  4  current state, for debug
- illegal_op  out  1  registered one-cycle pulse on an unsupported opcode

Function
REQ-003 State encoding SHALL be: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, ALUWB 7, BEQ 8, IMMEX 9, IMMWB 10, JUMP 11; codes 12-15 SHALL go to FETCH on the next edge.
REQ-004 Outputs SHALL be decoded from state (Moore), except for the mem_ready gating in REQ-006; any output not listed for a state SHALL be 0.
REQ-005 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOP=000, PCSrc=00.
REQ-006 FETCH: IRWrite=PCWrite=mem_ready; stay in FETCH while mem_ready=0; go to DECODE on the edge where mem_ready=1.
REQ-007 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOP=000; next state by Op:
- 100011 (lw) or 101011 (sw) -> MEMADR
- 000000 -> RTYPEEX
- 000100 -> BEQ
- 001000, 001100, 001101, 001010 -> IMMEX
- 000010 -> JUMP
- any other -> FETCH, with illegal_op=1 for the following cycle
REQ-008 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOP=000; next MEMRD if Op=100011, otherwise MEMWR.
REQ-009 MEMRD: IorD=1, MemRead=1; hold until mem_ready=1, then MEMWB.
REQ-010 MEMWB: RegDst=0, MemtoReg=1, RegWrite=1; then FETCH.
REQ-011 MEMWR: IorD=1, MemWrite=1; hold until mem_ready=1, then FETCH.
REQ-012 RTYPEEX: ALUSrcA=1, ALUSrcB=00, ALUOP=100; then ALUWB.
REQ-013 ALUWB: RegDst=1, MemtoReg=0, RegWrite=1; then FETCH.
REQ-014 BEQ: ALUSrcA=1, ALUSrcB=00, ALUOP=001, PCSrc=01, PCWriteCond=1; then FETCH.
REQ-015 IMMEX: ALUSrcA=1, ALUSrcB=10; ALUOP by Op: 001000->000, 001100->010, 001101->011, 001010->111; then IMMWB.
REQ-016 IMMWB: RegDst=0, MemtoReg=0, RegWrite=1; then FETCH.
REQ-017 JUMP: PCSrc=10, PCWrite=1; then FETCH.
REQ-018 Latency with mem_ready tied to 1 SHALL be:
- lw 5 cycles
- sw, R-type, addi/andi/ori/slti 4 cycles
- beq, j 3 cycles
REQ-019 ALUOP SHALL never be 100 outside RTYPEEX and never take values 101 or 110.
REQ-020 mem_ready SHALL be ignored in every state except FETCH, MEMRD and MEMWR.

Reset
REQ-021 While rst_n=0: state=FETCH, illegal_op=0, and IRWrite, PCWrite, PCWriteCond, MemRead, MemWrite, RegWrite are forced to 0.
REQ-022 Assertion of rst_n mid-instruction SHALL abort the instruction immediately, with no further write enables asserted.
REQ-023 After rst_n deasserts, the first rising edge SHALL evaluate FETCH normally.

Verification
REQ-024 The bench SHALL cover:
- lw: Op=100011, mem_ready=1 -> states 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4.
- R-type: Op=000000 -> ALUOP=100 in state 6, RegDst=1 and RegWrite=1 in state 7, then 0.
- ori: Op=001101 -> ALUOP=011 and ALUSrcB=10 in state 9; RegWrite=1 in state 10.
- Wait states: mem_ready=0 for 3 cycles in FETCH, then 1 -> state holds 0; IRWrite=PCWrite=0 until the ready cycle, then both 1 for exactly one cycle. Repeat for MEMWR with sw.
- Illegal opcode: Op=111111 -> DECODE to FETCH; illegal_op=1 for exactly one cycle.
- Reset mid-lw: rst_n=0 in state 3 -> state=0 asynchronously; all write enables and MemRead=0 until release.
